// File: rtl/toggle_monitor_if.sv
// toggle_monitor_if: run control, monitored input and measurement results of toggle_monitor
interface toggle_monitor_if #(parameter int CNT_W = 16);
   logic start;
   logic [CNT_W-1:0] n_toggles;
   logic in;
   logic busy, done, pass, err_timeout, err_period;
   logic [CNT_W-1:0] toggle_cnt, last_half;
   modport master (
      output start, n_toggles, in,
      input busy, done, pass, toggle_cnt, last_half, err_timeout, err_period
   );
   modport slave (
      input start, n_toggles, in,
      output busy, done, pass, toggle_cnt, last_half, err_timeout, err_period
   );
endinterface

// File: rtl/toggle_monitor.sv
// toggle_monitor: counts edges of an asynchronous input, measures half-periods and flags stalls or out-of-tolerance periods
module toggle_monitor #(
   parameter int CNT_W = 16,
   parameter int EXP_HALF = 10,
   parameter int TOL = 1,
   parameter int TIMEOUT = 64
) (
   input logic clk,
   input logic rst,
   toggle_monitor_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic signed [CNT_W:0] EXP = (CNT_W+1)'(EXP_HALF);
   localparam logic signed [CNT_W:0] TOLV = (CNT_W+1)'(TOL);
   state_t state, state_nx;
   logic s1, s2, s3;
   logic [CNT_W-1:0] gap, target, cnt, half;
   logic err_t, err_p;
   logic tgl, tmo, hit, go, active;
   logic signed [CNT_W:0] dev;
   assign tgl = s2 != s3;
   assign tmo = gap == TMO;
   assign hit = cnt == target;
   assign go = state == IDLE && bus.start;
   // once the target is reached the run is finishing; late edges or timeouts must not disturb results
   assign active = state == ARM || (state == MEASURE && !hit);
   assign dev = $signed({1'b0, gap}) - EXP;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = bus.start ? ARM : IDLE;
         ARM: state_nx = tmo ? DONE : tgl ? MEASURE : ARM;
         MEASURE: state_nx = (hit || tmo) ? DONE : MEASURE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {s1, s2, s3} <= '0;
         gap <= '0;
         target <= '0;
         cnt <= '0;
         half <= '0;
         err_t <= 1'b0;
         err_p <= 1'b0;
      end else begin
         {s1, s2, s3} <= {bus.in, s1, s2};
         if (go) begin
            target <= bus.n_toggles == '0 ? CNT_W'(1) : bus.n_toggles;
            cnt <= '0;
            gap <= '0;
            err_t <= 1'b0;
            err_p <= 1'b0;
         end else if (active) begin
            gap <= tgl ? CNT_W'(1) : gap + CNT_W'(!(&gap));
            cnt <= cnt + CNT_W'(tgl);
            if (tgl && state == MEASURE) begin
               half <= gap;
               err_p <= err_p | (dev > TOLV) | (dev < -TOLV);
            end
            err_t <= err_t | tmo;
         end
      end
   assign bus.busy = state == ARM || state == MEASURE;
   assign bus.done = state == DONE;
   assign bus.pass = state == DONE && !(err_t || err_p);
   assign bus.toggle_cnt = cnt;
   assign bus.last_half = half;
   assign bus.err_timeout = err_t;
   assign bus.err_period = err_p;
endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor: randomized bench comparing toggle_monitor against a run-level edge-timing model
module tb_toggle_monitor;
   localparam int TIMEOUT = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0, n_cmp = 0, n_bad = 0, exp_last = 0;
   int tog[$];
   toggle_monitor_if #(.CNT_W(16)) bus();
   toggle_monitor #(.CNT_W(16), .EXP_HALF(10), .TOL(1), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask
   function automatic int gap_for(input int kind, input int i);
      case (kind)
         0: return 10;
         1: return i == 6 ? 13 : 10;
         2: return int'($urandom_range(9, 11));
         default: return int'($urandom_range(3, 16));
      endcase
   endfunction
   task automatic run(input string nm, input int n, input int ntog, input int kind, input int dly, input bit spam);
      int s, base, cnt, lh, et, ep, tgt, done_at, t, got_at;
      bit first;
      tog.delete();
      t = cyc + dly;
      for (int i = 0; i < ntog; i++) begin
         if (i > 0) t += gap_for(kind, i);
         tog.push_back(t);
      end
      // a transition driven after clock k is acted on at clock k+3; start driven now is taken at clock cyc+1
      s = cyc + 1;
      base = s + 1;
      cnt = 0;
      lh = exp_last;
      et = 0;
      ep = 0;
      done_at = -1;
      first = 1'b1;
      tgt = n == 0 ? 1 : n;
      foreach (tog[i]) begin
         int d = tog[i] + 3;
         if (d > base + TIMEOUT) break;
         cnt++;
         if (!first) begin
            lh = d - base;
            if ((lh > 10 ? lh - 10 : 10 - lh) > 1) ep = 1;
         end
         first = 1'b0;
         if (d == base + TIMEOUT) begin
            et = 1;
            done_at = d;
            break;
         end
         base = d;
         if (cnt == tgt) begin
            done_at = d + 1;
            break;
         end
      end
      if (done_at < 0) begin
         et = 1;
         done_at = base + TIMEOUT;
      end
      bus.start = 1'b1;
      bus.n_toggles = 16'(n);
      got_at = -1;
      for (int j = 0; j < 400 && got_at < 0; j++) begin
         if (tog.size() > 0 && tog[0] == cyc) begin
            bus.in = ~bus.in;
            void'(tog.pop_front());
         end
         tick;
         if (j == 0) chk({nm, " busy"}, int'(bus.busy), 1);
         if (bus.done) got_at = cyc;
         else begin
            bus.start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.n_toggles = 16'($urandom);
         end
      end
      bus.start = 1'b0;
      chk({nm, " done_at"}, got_at, done_at);
      chk({nm, " toggle_cnt"}, int'(bus.toggle_cnt), cnt);
      chk({nm, " last_half"}, int'(bus.last_half), lh);
      chk({nm, " err_timeout"}, int'(bus.err_timeout), et);
      chk({nm, " err_period"}, int'(bus.err_period), ep);
      chk({nm, " pass"}, int'(bus.pass), (et == 0 && ep == 0) ? 1 : 0);
      exp_last = lh;
      for (int j = 0; j < 12; j++) begin
         if (j < 8 && tog.size() > 0 && tog[0] == cyc) begin
            bus.in = ~bus.in;
            void'(tog.pop_front());
         end
         tick;
         if (j == 0) chk({nm, " done pulse"}, int'(bus.done), 0);
      end
      tog.delete();
      chk({nm, " hold cnt"}, int'(bus.toggle_cnt), cnt);
      chk({nm, " hold half"}, int'(bus.last_half), lh);
      chk({nm, " hold errs"}, int'({bus.err_timeout, bus.err_period}), et * 2 + ep);
      chk({nm, " idle busy"}, int'(bus.busy), 0);
   endtask
   initial begin
      int seen;
      bus.start = 1'b0;
      bus.n_toggles = '0;
      bus.in = 1'b0;
      tick;
      tick;
      chk("rst busy", int'(bus.busy), 0);
      chk("rst done", int'(bus.done), 0);
      chk("rst pass", int'(bus.pass), 0);
      chk("rst cnt", int'(bus.toggle_cnt), 0);
      chk("rst half", int'(bus.last_half), 0);
      chk("rst errs", int'({bus.err_timeout, bus.err_period}), 0);
      rst = 1'b0;
      repeat (5) tick;
      chk("idle busy", int'(bus.busy), 0);
      run("nominal", 20, 20, 0, 4, 1'b0);
      run("late7", 20, 20, 1, 4, 1'b0);
      run("stall", 20, 5, 0, 4, 1'b0);
      run("hold", 3, 0, 0, 4, 1'b0);
      bus.start = 1'b1;
      bus.n_toggles = 16'd20;
      tick;
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.in = ~bus.in;
         repeat (10) tick;
      end
      chk("mid cnt", int'(bus.toggle_cnt), 10);
      chk("mid busy", int'(bus.busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst busy", int'(bus.busy), 0);
      chk("arst cnt", int'(bus.toggle_cnt), 0);
      chk("arst half", int'(bus.last_half), 0);
      chk("arst errs", int'({bus.done, bus.pass, bus.err_timeout, bus.err_period}), 0);
      tick;
      tick;
      rst = 1'b0;
      exp_last = 0;
      seen = 0;
      repeat (20) begin
         tick;
         seen |= int'(bus.done | bus.busy);
      end
      chk("arst quiet", seen, 0);
      run("after_rst", 4, 4, 0, 3, 1'b0);
      run("spam_n0", 0, 3, 0, 6, 1'b1);
      for (int r = 0; r < 25; r++)
         run("rand", int'($urandom_range(0, 8)), int'($urandom_range(0, 10)), int'($urandom_range(2, 3)),
             int'($urandom_range(1, 25)), r[0]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/toggle_monitor.md
TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of all counters and count/measurement ports.
REQ-002 Parameter EXP_HALF, default 10: expected half-period of `in`, in clk cycles.
REQ-003 Parameter TOL, default 1: allowed +/- deviation of a measured half-period from EXP_HALF, in clk cycles.
REQ-004 Parameter TIMEOUT, default 64: maximum number of clk cycles without an edge before a stall is declared.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin a measurement run; honoured only in IDLE.
REQ-008 n_toggles  in  CNT_W  number of edges to check, sampled when start is honoured; 0 is treated as 1.
REQ-009 in  in  1  monitored toggle signal, asynchronous to clk.
REQ-010 busy  out  1  high in ARM and MEASURE.
REQ-011 done  out  1  one-cycle pulse on entry to DONE.
REQ-012 pass  out  1  valid while done=1; 1 = no errors occurred in the run.
REQ-013 toggle_cnt  out  CNT_W  number of edges detected in the current or last run.
REQ-014 last_half  out  CNT_W  most recently measured half-period, in clk cycles.
REQ-015 err_timeout  out  1  sticky stall flag; cleared when start is honoured.
REQ-016 err_period  out  1  sticky out-of-tolerance flag; cleared when start is honoured.

Function
REQ-017 `in` passes through a 2-flop synchronizer (s1, s2) followed by a history flop s3; an edge is the condition s2 != s3, and either polarity counts.
REQ-018 The FSM has four states, with these transitions:
- IDLE -> ARM on start.
- ARM -> MEASURE on the first edge.
- MEASURE -> DONE when toggle_cnt reaches the target, or on timeout.
- DONE -> IDLE after exactly 1 cycle.
REQ-019 When start is honoured, the block latches target = max(n_toggles, 1), clears toggle_cnt, clears both error flags, and clears the gap counter.
REQ-020 The gap counter increments every cycle in ARM and MEASURE, saturates at all-ones, and reloads to 1 on every edge.
REQ-021 The first edge in ARM increments toggle_cnt to 1 and does not produce a half-period measurement.
REQ-022 Each subsequent edge in MEASURE:
- loads last_half with the gap counter value;
- increments toggle_cnt;
- sets err_period if |last_half - EXP_HALF| > TOL, computed at CNT_W+1 bits signed.
REQ-023 Timeout:
- If the gap counter reaches TIMEOUT in ARM or MEASURE before the next edge, err_timeout is set and the FSM goes to DONE.
- If a timeout and an edge occur in the same cycle, the edge is counted and the timeout is still flagged.
REQ-024 If the edge that makes toggle_cnt equal to the target arrives in the same cycle as start, start is ignored, because the block is busy.
REQ-025 In DONE, done=1 and pass = ~(err_timeout | err_period); toggle_cnt, last_half and the error flags hold until the next honoured start.
REQ-026 Edges detected in IDLE or DONE are ignored and leave all outputs unchanged.
REQ-027 start asserted while busy=1 has no effect.
REQ-028 If n_toggles=1, the run completes on the first edge: ARM -> MEASURE, then DONE on the following cycle with last_half unchanged.
REQ-029 Latency: done rises a fixed number of cycles after the final `in` transition, no more than 4 clk cycles (2 synchronizer, 1 history, 1 FSM register).

Reset
REQ-030 rst=1 immediately forces:
- FSM to IDLE;
- s1, s2, s3 to 0;
- busy, done, pass, err_timeout, err_period to 0;
- toggle_cnt, last_half and the gap counter to 0.
REQ-031 rst asserted mid-run aborts the run with no done pulse; after deassertion the block waits in IDLE for start.
REQ-032 The first rising clk edge after rst deasserts treats s2 != s3 as a real edge, but such an edge is ignored in IDLE.

Verification
REQ-033 Toggle `in` every 10 clk cycles; start with n_toggles=20 -> done after the 20th edge, pass=1, toggle_cnt=20, last_half=10.
REQ-034 As REQ-033, but edge 7 arrives 3 cycles late (gap of 13) -> err_period=1, done after edge 20, pass=0.
REQ-035 Stop toggling after 5 edges, with n_toggles=20 -> err_timeout=1 exactly 64 cycles after edge 5, done, pass=0, toggle_cnt=5.
REQ-036 start with `in` held constant -> ARM persists for 64 cycles, then err_timeout=1, toggle_cnt=0, pass=0.
REQ-037 Assert rst at edge 10 of a 20-edge run -> all outputs 0 immediately, no done pulse; a new start with n_toggles=4 then completes with pass=1.
REQ-038 Pulse start repeatedly during a run, and use n_toggles=0 -> the extra start pulses are ignored; the n_toggles=0 run ends after 1 edge.
